// File: rtl/neuron_input_buffer.sv
// N-lane serial-in / parallel-reload staging buffer feeding the neuron bank.
// Optional build macro NEURON_FB_RELU_EN clamps negative feedback lanes to zero on reload.
module neuron_input_buffer #(
    parameter int DATA_W  = 8,
    parameter int N_LANES = 4,
    parameter int CNT_W   = 3
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [1:0]                  sel,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        fb_valid,
    input  logic [N_LANES*DATA_W-1:0]   fb_data,
    input  logic                        consume,
    output logic [N_LANES*DATA_W-1:0]   neuron_in,
    output logic [CNT_W-1:0]            fill_count,
    output logic                        full
);

    typedef enum logic [1:0] {
        MODE_SHIFT   = 2'b00,
        MODE_HOLD    = 2'b01,
        MODE_LOAD_FB = 2'b10,
        MODE_CLEAR   = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_LANES);

    mode_e             mode;
    logic [DATA_W-1:0] lane_q [N_LANES];
    logic [DATA_W-1:0] lane_d [N_LANES];
    logic [DATA_W-1:0] fb_lane [N_LANES];
    logic [CNT_W-1:0]  fill_count_q, fill_count_d;
    logic              full_q, full_d;
    logic              accept;

    assign mode     = mode_e'(sel);
    assign in_ready = (mode == MODE_SHIFT) && !full_q;
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] fb_raw;
            assign fb_raw = fb_data[gi*DATA_W +: DATA_W];
`ifdef NEURON_FB_RELU_EN
            assign fb_lane[gi] = fb_raw[DATA_W-1] ? '0 : fb_raw;
`else
            assign fb_lane[gi] = fb_raw;
`endif
            assign neuron_in[gi*DATA_W +: DATA_W] = lane_q[gi];
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            lane_d[k] = lane_q[k];
        end
        fill_count_d = fill_count_q;

        case (mode)
            MODE_CLEAR: begin
                for (int k = 0; k < N_LANES; k++) begin
                    lane_d[k] = '0;
                end
                fill_count_d = '0;
            end
            MODE_LOAD_FB: begin
                // Whole LOAD_FB mode outranks consume, even when fb_valid is low.
                if (fb_valid) begin
                    for (int k = 0; k < N_LANES; k++) begin
                        lane_d[k] = fb_lane[k];
                    end
                    fill_count_d = FULL_CNT;
                end
            end
            default: begin
                if (accept) begin
                    lane_d[0] = in_data;
                    for (int k = 1; k < N_LANES; k++) begin
                        lane_d[k] = lane_q[k-1];
                    end
                end
                // accept implies !full, so the increment can never pass N_LANES.
                if (consume) begin
                    fill_count_d = accept ? CNT_W'(1) : '0;
                end else if (accept) begin
                    fill_count_d = fill_count_q + CNT_W'(1);
                end
            end
        endcase

        full_d = (fill_count_d == FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int k = 0; k < N_LANES; k++) begin
                lane_q[k] <= '0;
            end
            fill_count_q <= '0;
            full_q       <= 1'b0;
        end else begin
            for (int k = 0; k < N_LANES; k++) begin
                lane_q[k] <= lane_d[k];
            end
            fill_count_q <= fill_count_d;
            full_q       <= full_d;
        end
    end

    assign fill_count = fill_count_q;
    assign full       = full_q;

endmodule

// File: tb/tb_neuron_input_buffer.sv
// Self-checking bench for neuron_input_buffer: queue-based reference model,
// per-cycle compare on the falling edge, directed scenarios plus random traffic.
module tb_neuron_input_buffer;

    localparam int DW = 8;
    localparam int NL = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [1:0]      sel;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            fb_valid;
    logic [NL*DW-1:0] fb_data;
    logic            consume;
    logic [NL*DW-1:0] neuron_in;
    logic [CW-1:0]   fill_count;
    logic            full;

    neuron_input_buffer #(.DATA_W(DW), .N_LANES(NL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fb_valid   (fb_valid),
        .fb_data    (fb_data),
        .consume    (consume),
        .neuron_in  (neuron_in),
        .fill_count (fill_count),
        .full       (full)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: m_lane[0] is lane0 (newest sample), m_cnt is fresh-sample count.
    logic [DW-1:0] m_lane [$];
    int            m_cnt = 0;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef NEURON_FB_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (rstn) begin
            m_lane.delete();
            repeat (NL) m_lane.push_back('0);
            m_cnt = 0;
        end else if (sel == 2'b11) begin
            foreach (m_lane[k]) m_lane[k] = '0;
            m_cnt = 0;
        end else if (sel == 2'b10) begin
            if (fb_valid) begin
                foreach (m_lane[k]) m_lane[k] = relu(fb_data[k*DW +: DW]);
                m_cnt = NL;
            end
        end else begin
            acc = (sel == 2'b00) && in_valid && (m_cnt < NL);
            if (acc) begin
                m_lane.push_front(in_data);
                void'(m_lane.pop_back());
            end
            if (consume) m_cnt = acc ? 1 : 0;
            else if (acc) m_cnt = m_cnt + 1;
        end
    end

    logic [NL*DW-1:0] exp_vec;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NL; k++) exp_vec[k*DW +: DW] = m_lane[k];
            chk("neuron_in", neuron_in, exp_vec);
            chk("fill_count", fill_count, m_cnt);
            chk("full", full, m_cnt == NL);
            chk("in_ready", in_ready, (sel == 2'b00) && (m_cnt != NL));
        end
    end

    task automatic drive(input logic r, input logic [1:0] s, input logic iv, input logic [DW-1:0] id,
                         input logic fv, input logic [NL*DW-1:0] fd, input logic c);
        rstn = r; sel = s; in_valid = iv; in_data = id; fb_valid = fv; fb_data = fd; consume = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [NL*DW-1:0] fb_exp;

    initial begin
        drive(1'b1, 2'b00, 1'b0, '0, 1'b0, '0, 1'b0);
        // Reset for two cycles with random inputs on every other pin.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 32'($urandom), 1'($urandom));
            step();
            chk_en = 1;
        end
        chk("rst_lanes", neuron_in, 32'h0);
        chk("rst_count", fill_count, 3'd0);
        chk("rst_full", full, 1'b0);

        // Four back-to-back samples fill the buffer.
        drive(1'b0, 2'b00, 1'b1, 8'h11, 1'b0, '0, 1'b0); step();
        drive(1'b0, 2'b00, 1'b1, 8'h22, 1'b0, '0, 1'b0); step();
        drive(1'b0, 2'b00, 1'b1, 8'h33, 1'b0, '0, 1'b0); step();
        drive(1'b0, 2'b00, 1'b1, 8'h44, 1'b0, '0, 1'b0); step();
        chk("fill4_lanes", neuron_in, 32'h11223344);
        chk("fill4_full", full, 1'b1);
        chk("fill4_ready", in_ready, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 8'h55, 1'b0, '0, 1'b0); step();
        chk("held_off_lanes", neuron_in, 32'h11223344);
        chk("held_off_count", fill_count, 3'd4);

        // Consume while full; the pending 0x66 lands once the buffer reopens.
        drive(1'b0, 2'b00, 1'b1, 8'h66, 1'b0, '0, 1'b1); step();
        chk("consume_count", fill_count, 3'd0);
        drive(1'b0, 2'b00, 1'b1, 8'h66, 1'b0, '0, 1'b0); step();
        chk("refill_count", fill_count, 3'd1);
        chk("refill_lane0", neuron_in[7:0], 8'h66);

        // Parallel feedback load, with consume the same cycle (load wins).
        drive(1'b0, 2'b10, 1'b1, 8'h77, 1'b1, 32'h807F01FF, 1'b1); step();
`ifdef NEURON_FB_RELU_EN
        fb_exp = 32'h007F0100;
`else
        fb_exp = 32'h807F01FF;
`endif
        chk("fb_lanes", neuron_in, fb_exp);
        chk("fb_full", full, 1'b1);
        chk("fb_count", fill_count, 3'd4);

        // Restart, fill two, hold three cycles, then resume.
        drive(1'b0, 2'b01, 1'b0, '0, 1'b0, '0, 1'b1); step();
        drive(1'b0, 2'b00, 1'b1, 8'hA1, 1'b0, '0, 1'b0); step();
        drive(1'b0, 2'b00, 1'b1, 8'hA2, 1'b0, '0, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b01, 1'b1, 8'hEE, 1'b0, '0, 1'b0); step();
        end
        chk("hold_count", fill_count, 3'd2);
        chk("hold_lanes", neuron_in[15:0], 16'hA1A2);
        drive(1'b0, 2'b00, 1'b1, 8'hA3, 1'b0, '0, 1'b0); step();
        chk("resume_count", fill_count, 3'd3);
        chk("resume_lane0", neuron_in[7:0], 8'hA3);

        // CLEAR mid-fill, then reset against a competing feedback load.
        drive(1'b0, 2'b11, 1'b1, 8'hBB, 1'b1, 32'hDEADBEEF, 1'b0); step();
        chk("clear_lanes", neuron_in, 32'h0);
        chk("clear_count", fill_count, 3'd0);
        drive(1'b0, 2'b00, 1'b1, 8'hC1, 1'b0, '0, 1'b0); step();
        drive(1'b1, 2'b10, 1'b1, 8'hC2, 1'b1, 32'h12345678, 1'b0); step();
        chk("rst_fb_lanes", neuron_in, 32'h0);
        chk("rst_fb_count", fill_count, 3'd0);

        // Random traffic; consume is suppressed only in LOAD_FB without fb_valid.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] s;
            logic fv, c;
            int r;
            r  = $urandom_range(0, 9);
            s  = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            fv = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 5) == 0);
            if (s == 2'b10 && !fv) c = 1'b0;
            drive(($urandom_range(0, 59) == 0), s, 1'($urandom), 8'($urandom),
                  fv, 32'($urandom), c);
            step();
        end

        drive(1'b0, 2'b01, 1'b0, '0, 1'b0, '0, 1'b0);
        step();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
